sipo: RTL and testbench

- Serial-in/parallel-out collector: gathers SYMS symbols of SYM_W bits, MSB-first, into one WORD_W-bit word.
- Receive-side counterpart of the 2-bit-per-cycle serialiser in the Viterbi datapath. Accepts the serialiser's symbol stream and restores the original 16-bit word.
- Two-stage buffer: an assembly shift register plus an output holding register with a valid/ready handshake. Assembly of the next word continues while the previous word waits for the consumer.

---
 rtl/sipo.sv | 91 +++++++++
 tb/tb_sipo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sipo.sv
// Serial-in/parallel-out collector: SYMS symbols of SYM_W bits, MSB-first, into one
// word held behind a valid/ready output slot. Define SIPO_WORD_CNT_EN to add word_cnt_o.
module sipo #(
  parameter int SYM_W = 2,
  parameter int SYMS  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SYM_W-1:0]        data_serial_i,
  input  logic                    valid_serial_i,
  input  logic                    flush_i,
  output logic [SYM_W*SYMS-1:0]   data_parallel_o,
  output logic                    valid_parallel_o,
  input  logic                    ready_parallel_i,
  output logic                    busy_o,
`ifdef SIPO_WORD_CNT_EN
  output logic [15:0]             word_cnt_o,
`endif
  output logic                    overflow_o
);

  localparam int WORD_W = SYM_W * SYMS;
  localparam int CNT_W  = $clog2(SYMS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SYMS - 1);

  // Output handshake: a word transfers in any cycle where valid_parallel_o and
  // ready_parallel_i are both 1; while valid is high and ready low, data is held stable.

  logic [WORD_W-1:0] asm_reg;
  logic [CNT_W-1:0]  sym_cnt;
  logic              accept;
  logic              complete;
  logic              slot_free;
  logic              deliver;
  logic [WORD_W-1:0] word;

  assign accept    = valid_serial_i & ~flush_i;
  assign complete  = accept & (sym_cnt == LAST);
  assign slot_free = ~valid_parallel_o | ready_parallel_i;
  assign deliver   = valid_parallel_o & ready_parallel_i;
  // The final symbol goes straight into the word so it is visible one cycle later.
  assign word      = {asm_reg[WORD_W-SYM_W-1:0], data_serial_i};
  assign busy_o    = (sym_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_reg <= '0;
      sym_cnt <= '0;
    end else if (flush_i || complete) begin
      asm_reg <= '0;
      sym_cnt <= '0;
    end else if (accept) begin
      asm_reg <= word;
      sym_cnt <= sym_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_parallel_o  <= '0;
      valid_parallel_o <= 1'b0;
    end else if (complete && slot_free) begin
      data_parallel_o  <= word;
      valid_parallel_o <= 1'b1;
    end else if (deliver) begin
      valid_parallel_o <= 1'b0;
    end
  end

  // Sticky drop flag; only flush or reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_o <= 1'b0;
    end else if (flush_i) begin
      overflow_o <= 1'b0;
    end else if (complete && !slot_free) begin
      overflow_o <= 1'b1;
    end
  end

`ifdef SIPO_WORD_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_o <= '0;
    end else if (deliver) begin
      word_cnt_o <= word_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sipo.sv
// Bench for sipo: directed scenarios plus random traffic against a symbol-queue
// reference model, with a scoreboard of words expected at the consumer.
module tb_sipo;

  localparam int SYM_W  = 2;
  localparam int SYMS   = 8;
  localparam int WORD_W = SYM_W * SYMS;

  logic              clk;
  logic              rst_n;
  logic [SYM_W-1:0]  data_serial_i;
  logic              valid_serial_i;
  logic              flush_i;
  logic [WORD_W-1:0] data_parallel_o;
  logic              valid_parallel_o;
  logic              ready_parallel_i;
  logic              busy_o;
  logic              overflow_o;
`ifdef SIPO_WORD_CNT_EN
  logic [15:0]       word_cnt_o;
`endif

  sipo #(.SYM_W(SYM_W), .SYMS(SYMS)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .data_serial_i    (data_serial_i),
    .valid_serial_i   (valid_serial_i),
    .flush_i          (flush_i),
    .data_parallel_o  (data_parallel_o),
    .valid_parallel_o (valid_parallel_o),
    .ready_parallel_i (ready_parallel_i),
    .busy_o           (busy_o),
`ifdef SIPO_WORD_CNT_EN
    .word_cnt_o       (word_cnt_o),
`endif
    .overflow_o       (overflow_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // reference model: symbols of the word in progress, plus the output slot
  int                part_q[$];
  logic              m_valid;
  logic [WORD_W-1:0] m_data;
  logic              m_ovf;
  logic [15:0]       m_cnt;
  logic [WORD_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    part_q.delete();
    exp_q.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_ovf   = 1'b0;
    m_cnt   = '0;
  endtask

  task automatic model_update(input logic vs, input logic [SYM_W-1:0] ds,
                              input logic fl, input logic rdy);
    bit got_word = 0;
    logic [WORD_W-1:0] w = '0;
    if (m_valid && rdy) m_cnt = m_cnt + 16'd1;
    if (fl) begin
      part_q.delete();
      m_ovf = 1'b0;
    end else if (vs) begin
      part_q.push_back(int'(ds));
      if (part_q.size() == SYMS) begin
        foreach (part_q[i]) w = WORD_W'(w * (1 << SYM_W) + part_q[i]);
        part_q.delete();
        got_word = 1;
      end
    end
    if (got_word && (!m_valid || rdy)) begin
      m_data  = w;
      m_valid = 1'b1;
      exp_q.push_back(w);
    end else begin
      if (got_word) m_ovf = 1'b1;
      if (m_valid && rdy) m_valid = 1'b0;
    end
  endtask

  task automatic compare_outputs(input string tag);
    check({tag, ".valid"}, 32'(valid_parallel_o), 32'(m_valid));
    check({tag, ".data"},  32'(data_parallel_o),  32'(m_data));
    check({tag, ".busy"},  32'(busy_o),           32'(part_q.size() != 0));
    check({tag, ".ovf"},   32'(overflow_o),       32'(m_ovf));
`ifdef SIPO_WORD_CNT_EN
    check({tag, ".wcnt"},  32'(word_cnt_o),       32'(m_cnt));
`endif
  endtask

  // driver: one clock cycle with the given inputs
  task automatic step(input logic vs, input logic [SYM_W-1:0] ds,
                      input logic fl, input logic rdy, input string tag);
    valid_serial_i   = vs;
    data_serial_i    = ds;
    flush_i          = fl;
    ready_parallel_i = rdy;
    if (valid_parallel_o && rdy) begin
      if (exp_q.size() == 0) check({tag, ".sb_empty"}, 32'(1), 32'(0));
      else                   check({tag, ".sb_word"}, 32'(data_parallel_o), 32'(exp_q.pop_front()));
    end
    model_update(vs, ds, fl, rdy);
    @(posedge clk);
    #1;
    compare_outputs(tag);
  endtask

  function automatic logic [SYM_W-1:0] sym_of(input logic [WORD_W-1:0] w, input int i);
    return SYM_W'(w >> (SYM_W * (SYMS - 1 - i)));
  endfunction

  task automatic feed_word(input logic [WORD_W-1:0] w, input logic rdy,
                           input logic last_rdy, input int max_gap, input string tag);
    for (int i = 0; i < SYMS; i++) begin
      int gap = (max_gap == 0) ? 0 : int'($urandom_range(1, max_gap));
      for (int g = 0; g < gap; g++) step(1'b0, SYM_W'($urandom), 1'b0, rdy, tag);
      step(1'b1, sym_of(w, i), 1'b0, (i == SYMS - 1) ? last_rdy : rdy, tag);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid_serial_i = 1'b0;
    data_serial_i = '0;
    flush_i = 1'b0;
    ready_parallel_i = 1'b0;
    #2;
    model_reset();
    compare_outputs("reset_async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    compare_outputs("reset_release");
  endtask

  logic [SYM_W-1:0] t1_syms [SYMS];

  initial begin
    do_reset();

    // Known 8-symbol stream -> C9F1
    t1_syms = '{2'b11, 2'b00, 2'b10, 2'b01, 2'b11, 2'b11, 2'b00, 2'b01};
    for (int i = 0; i < SYMS; i++) begin
      step(1'b1, t1_syms[i], 1'b0, 1'b1, "t1");
      check("t1.busy_const", 32'(busy_o), 32'(i != SYMS - 1));
    end
    check("t1.word", 32'(data_parallel_o), 32'h0000C9F1);
    check("t1.valid", 32'(valid_parallel_o), 32'(1));
    step(1'b0, '0, 1'b0, 1'b1, "t1_idle");

    // Serialiser loopback of A5C3, valid for exactly one cycle
    feed_word(16'hA5C3, 1'b1, 1'b1, 0, "t2");
    check("t2.word", 32'(data_parallel_o), 32'h0000A5C3);
    step(1'b0, '0, 1'b0, 1'b1, "t2_idle");
    check("t2.valid_drop", 32'(valid_parallel_o), 32'(0));

    // Overflow while the consumer stalls
    feed_word(16'h1234, 1'b0, 1'b0, 0, "t3");
    feed_word(16'h5678, 1'b0, 1'b0, 0, "t3");
    check("t3.held", 32'(data_parallel_o), 32'h00001234);
    check("t3.ovf", 32'(overflow_o), 32'(1));
    step(1'b0, '0, 1'b0, 1'b1, "t3_drain");
    check("t3.valid_drop", 32'(valid_parallel_o), 32'(0));
    check("t3.ovf_sticky", 32'(overflow_o), 32'(1));
    step(1'b0, '0, 1'b1, 1'b1, "t3_flush");
    check("t3.ovf_clear", 32'(overflow_o), 32'(0));

    // Flush discards a partial word including a same-cycle symbol
    for (int i = 0; i < 3; i++) step(1'b1, 2'b10, 1'b0, 1'b1, "t4_part");
    step(1'b1, 2'b01, 1'b1, 1'b1, "t4_flush");
    check("t4.busy_cleared", 32'(busy_o), 32'(0));
    feed_word(16'hFFFF, 1'b1, 1'b1, 0, "t4");
    check("t4.word", 32'(data_parallel_o), 32'h0000FFFF);
    check("t4.ovf", 32'(overflow_o), 32'(0));
    step(1'b0, '0, 1'b0, 1'b1, "t4_idle");

    // Gapped symbols, then completion replacing a pending word with ready=1
    feed_word(16'h0F0F, 1'b0, 1'b0, 5, "t5");
    check("t5.word", 32'(data_parallel_o), 32'h00000F0F);
    feed_word(16'hBEEF, 1'b0, 1'b1, 3, "t5b");
    check("t5.replace", 32'(data_parallel_o), 32'h0000BEEF);
    check("t5.no_ovf", 32'(overflow_o), 32'(0));
    step(1'b0, '0, 1'b0, 1'b1, "t5_idle");

    // Back-to-back full rate with ready held high
    for (int k = 0; k < 4; k++) feed_word(16'($urandom), 1'b1, 1'b1, 0, "t6");
    check("t6.no_ovf", 32'(overflow_o), 32'(0));

    // Random traffic
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 3) != 0, SYM_W'($urandom), $urandom_range(0, 79) == 0,
           $urandom_range(0, 2) != 0, "rnd");

    // Asynchronous reset mid-word with a word pending
    feed_word(16'h1357, 1'b0, 1'b0, 0, "t7");
    for (int i = 0; i < 3; i++) step(1'b1, 2'b11, 1'b0, 1'b0, "t7_part");
    check("t7.busy_pre", 32'(busy_o), 32'(1));
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_outputs("t7_async");
    check("t7.data_zero", 32'(data_parallel_o), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    feed_word(16'h2468, 1'b1, 1'b1, 2, "t7_after");
    step(1'b0, '0, 1'b0, 1'b1, "t7_idle");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
